// File: rtl/positron_layer_frame_arbiter.sv
// rtl/positron_layer_frame_arbiter.sv - frame-granular two-way arbiter in front of a positron layer
//
// Grants whole input frames from one of two posit streams to the layer, marks sow/eow,
// remembers the owner of each frame in a small ID FIFO and tags each result frame with it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_rts_i/s_eow_i/s_posit_i  two upstream requesters (bit k / slice k); s_rtr_o accepts
//   m_rts_o/m_rtr_i            word handshake toward the layer, m_sow_o/m_eow_o frame marks
//   m_posit_o                  data toward the layer
//   l_rts_i/l_rtr_o            result handshake from the layer, l_eow_i/l_posit_i passed on
//   r_rts_o/r_rtr_i            tagged result handshake downstream
//   r_eow_o/r_posit_o          passthrough of l_eow_i/l_posit_i
//   r_id_o/r_last_o            owner of the current result frame, last word of that frame
//   err_o                      sticky: layer offered a result while no frame was in flight
module positron_layer_frame_arbiter #(
  parameter int NB_UPSTREAM_POSITRON = 784,
  parameter int NB_POSITRON          = 20,
  parameter int POSIT_WIDTH          = 16,
  parameter int ID_FIFO_DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               s_rts_i,
  input  logic [1:0]               s_eow_i,
  input  logic [2*POSIT_WIDTH-1:0] s_posit_i,
  output logic [1:0]               s_rtr_o,
  output logic                     m_rts_o,
  input  logic                     m_rtr_i,
  output logic                     m_sow_o,
  output logic                     m_eow_o,
  output logic [POSIT_WIDTH-1:0]   m_posit_o,
  input  logic                     l_rts_i,
  input  logic                     l_eow_i,
  input  logic [POSIT_WIDTH-1:0]   l_posit_i,
  output logic                     l_rtr_o,
  output logic                     r_rts_o,
  input  logic                     r_rtr_i,
  output logic                     r_eow_o,
  output logic                     r_id_o,
  output logic                     r_last_o,
  output logic [POSIT_WIDTH-1:0]   r_posit_o,
  output logic                     err_o
);

  localparam int WC_W = (NB_UPSTREAM_POSITRON > 1) ? $clog2(NB_UPSTREAM_POSITRON) : 1;
  localparam int RC_W = (NB_POSITRON > 1) ? $clog2(NB_POSITRON) : 1;
  localparam int AW   = $clog2(ID_FIFO_DEPTH);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(NB_UPSTREAM_POSITRON - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(NB_POSITRON - 1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(ID_FIFO_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state;
  logic                     g;
  logic                     prio;
  logic [WC_W-1:0]          wc;
  logic [RC_W-1:0]          rc;
  logic [ID_FIFO_DEPTH-1:0] id_mem;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW:0]              count;

  logic fifo_full, fifo_empty, busy, m_acc, grant, pick, r_acc, pop;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign busy       = (state == BUSY);

  // Input side: zero-latency mux from the granted requester straight to the layer.
  assign m_rts_o   = busy & s_rts_i[g];
  assign m_posit_o = g ? s_posit_i[2*POSIT_WIDTH-1:POSIT_WIDTH] : s_posit_i[POSIT_WIDTH-1:0];
  assign s_rtr_o   = !busy ? 2'b00 : (g ? {m_rtr_i, 1'b0} : {1'b0, m_rtr_i});
  assign m_sow_o   = m_rts_o & (wc == '0);
  assign m_eow_o   = m_rts_o & ((wc == WC_LAST) | s_eow_i[g]);
  assign m_acc     = m_rts_o & m_rtr_i;

  // A new grant is only issued from IDLE, which yields the one-cycle bubble between frames.
  assign grant = !busy & (|s_rts_i) & !fifo_full;
  assign pick  = s_rts_i[prio] ? prio : ~prio;

  // Result side: nothing is accepted from the layer unless a frame owner is on record.
  assign r_rts_o   = l_rts_i & !fifo_empty;
  assign l_rtr_o   = r_rtr_i & !fifo_empty;
  assign r_id_o    = id_mem[rd_ptr];
  assign r_last_o  = (rc == RC_LAST);
  assign r_eow_o   = l_eow_i;
  assign r_posit_o = l_posit_i;
  assign r_acc     = r_rts_o & r_rtr_i;
  assign pop       = r_acc & r_last_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      g     <= 1'b0;
      prio  <= 1'b0;
      wc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= BUSY;
            g     <= pick;
          end
        end
        BUSY: begin
          if (m_acc) begin
            if (m_eow_o) begin
              wc    <= '0;
              prio  <= ~g;
              state <= IDLE;
            end else begin
              wc <= wc + WC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Owner FIFO, result word counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rc     <= '0;
      err_o  <= 1'b0;
    end else begin
      if (grant) begin
        id_mem[wr_ptr] <= pick;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({grant, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (r_acc) begin
        rc <= pop ? '0 : rc + RC_W'(1);
      end
      if (l_rts_i & fifo_empty) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_positron_layer_frame_arbiter.sv
// tb/tb_positron_layer_frame_arbiter.sv - self-checking bench for positron_layer_frame_arbiter
module tb_positron_layer_frame_arbiter;

  localparam int N  = 4;
  localparam int NP = 2;
  localparam int W  = 16;
  localparam int D  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     s_rts_i = '0;
  logic [1:0]     s_eow_i = '0;
  logic [2*W-1:0] s_posit_i = '0;
  logic [1:0]     s_rtr_o;
  logic           m_rts_o, m_sow_o, m_eow_o;
  logic           m_rtr_i = 1'b0;
  logic [W-1:0]   m_posit_o;
  logic           l_rts_i = 1'b0, l_eow_i = 1'b0;
  logic [W-1:0]   l_posit_i = '0;
  logic           l_rtr_o;
  logic           r_rts_o, r_eow_o, r_id_o, r_last_o, err_o;
  logic           r_rtr_i = 1'b0;
  logic [W-1:0]   r_posit_o;

  positron_layer_frame_arbiter #(
    .NB_UPSTREAM_POSITRON(N),
    .NB_POSITRON(NP),
    .POSIT_WIDTH(W),
    .ID_FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_rts_i(s_rts_i), .s_eow_i(s_eow_i), .s_posit_i(s_posit_i), .s_rtr_o(s_rtr_o),
    .m_rts_o(m_rts_o), .m_rtr_i(m_rtr_i), .m_sow_o(m_sow_o), .m_eow_o(m_eow_o),
    .m_posit_o(m_posit_o),
    .l_rts_i(l_rts_i), .l_eow_i(l_eow_i), .l_posit_i(l_posit_i), .l_rtr_o(l_rtr_o),
    .r_rts_o(r_rts_o), .r_rtr_i(r_rtr_i), .r_eow_o(r_eow_o), .r_id_o(r_id_o),
    .r_last_o(r_last_o), .r_posit_o(r_posit_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; logic sow; logic eow; } mexp_t;
  typedef struct { logic [15:0] d; logic id; logic last; logic eow; } rexp_t;
  typedef struct { int k; int n; logic [15:0] base; logic exp_id; } vec_t;

  logic [16:0] src0[$];
  logic [16:0] src1[$];
  logic [16:0] lres_q[$];
  mexp_t       mexp_q[$];
  rexp_t       rexp_q[$];
  int          sow_cyc[$];
  int          pop_cyc[$];
  vec_t        vecs[5];
  int          gaps[3];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_seq = 0;
  int   lay_seq = 0;
  logic l_force = 1'b0, l_en = 1'b1, r_en = 1'b1, m_rtr_en = 1'b1, m_rtr_tog = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    s_rts_i[0]       = (src0.size() > 0);
    s_eow_i[0]       = (src0.size() > 0) ? src0[0][16] : 1'b0;
    s_posit_i[W-1:0] = (src0.size() > 0) ? src0[0][15:0] : '0;
    s_rts_i[1]       = (src1.size() > 0);
    s_eow_i[1]       = (src1.size() > 0) ? src1[0][16] : 1'b0;
    s_posit_i[2*W-1:W] = (src1.size() > 0) ? src1[0][15:0] : '0;
    m_rtr_i   = m_rtr_tog ? cyc[0] : m_rtr_en;
    l_rts_i   = l_force | (l_en & (lres_q.size() > 0));
    l_eow_i   = (lres_q.size() > 0) ? lres_q[0][16] : 1'b0;
    l_posit_i = (lres_q.size() > 0) ? lres_q[0][15:0] : '0;
    r_rtr_i   = r_en;
  endtask

  // Queues the words of one frame on requester k and the scoreboard entries it must produce.
  task automatic push_frame(input int k, input int n, input logic [15:0] base, input logic id);
    mexp_t me;
    rexp_t re;
    for (int i = 0; i < n; i++) begin
      if (k == 0) src0.push_back({(i == n-1) && (n < N), 16'(base + i)});
      else        src1.push_back({(i == n-1) && (n < N), 16'(base + i)});
      me.d = 16'(base + i); me.sow = (i == 0); me.eow = (i == n-1);
      mexp_q.push_back(me);
    end
    for (int j = 0; j < NP; j++) begin
      re.d = 16'(16'hA000 + exp_seq); re.id = id; re.last = (j == NP-1);
      re.eow = (exp_seq % 3 == 2);
      rexp_q.push_back(re);
      exp_seq++;
    end
    drive();
  endtask

  task automatic step();
    logic  a0, a1, al;
    mexp_t me;
    rexp_t re;
    @(negedge clk);
    if (m_rts_o && m_rtr_i) begin
      if (mexp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL m_unexpected actual=%0h required=none", m_posit_o);
      end else begin
        me = mexp_q.pop_front();
        chk("m_word", 32'({m_posit_o, m_sow_o, m_eow_o}), 32'({me.d, me.sow, me.eow}));
      end
      if (m_sow_o) sow_cyc.push_back(cyc);
      if (m_eow_o) begin
        for (int j = 0; j < NP; j++) begin
          lres_q.push_back({(lay_seq % 3 == 2), 16'(16'hA000 + lay_seq)});
          lay_seq++;
        end
      end
    end
    if (r_rts_o && r_rtr_i) begin
      if (rexp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected actual=%0h required=none", r_posit_o);
      end else begin
        re = rexp_q.pop_front();
        chk("r_word", 32'({r_posit_o, r_id_o, r_last_o, r_eow_o}),
            32'({re.d, re.id, re.last, re.eow}));
      end
      if (r_last_o) pop_cyc.push_back(cyc);
    end
    a0 = s_rts_i[0] & s_rtr_o[0];
    a1 = s_rts_i[1] & s_rtr_o[1];
    al = l_rts_i & l_rtr_o;
    @(posedge clk);
    cyc++;
    #1;
    if (a0 && src0.size() > 0) void'(src0.pop_front());
    if (a1 && src1.size() > 0) void'(src1.pop_front());
    if (al && lres_q.size() > 0) void'(lres_q.pop_front());
    drive();
  endtask

  task automatic wait_m(input int target, input int budget);
    int n = 0;
    while (mexp_q.size() > target && n < budget) begin
      step();
      n++;
    end
    chk("wait_m_timeout", 32'(n >= budget), 32'(0));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((mexp_q.size() > 0 || rexp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= budget), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src0.delete(); src1.delete(); lres_q.delete(); mexp_q.delete(); rexp_q.delete();
    sow_cyc.delete(); pop_cyc.delete();
    exp_seq = 0; lay_seq = 0;
    l_force = 1'b0; l_en = 1'b1; r_en = 1'b1; m_rtr_en = 1'b1; m_rtr_tog = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{k: 0, n: 4, base: 16'h0100, exp_id: 1'b0};
    vecs[1] = '{k: 1, n: 2, base: 16'h1100, exp_id: 1'b1};
    vecs[2] = '{k: 1, n: 1, base: 16'h1200, exp_id: 1'b1};
    vecs[3] = '{k: 0, n: 3, base: 16'h0300, exp_id: 1'b0};
    vecs[4] = '{k: 1, n: 4, base: 16'h1400, exp_id: 1'b1};
    gaps    = '{5, 3, 5};

    // Reset values, error on an orphan result, then a reset in the middle of a frame.
    do_reset();
    @(negedge clk);
    chk("reset_outs", 32'({s_rtr_o, m_rts_o, m_sow_o, m_eow_o, r_rts_o, err_o}), 32'(0));
    @(posedge clk); #1;
    l_force = 1'b1; drive();
    @(negedge clk);
    chk("orphan_l_rtr", 32'({l_rtr_o, r_rts_o}), 32'(0));
    @(posedge clk); #1;
    l_force = 1'b0; drive();
    @(negedge clk);
    chk("orphan_err", 32'(err_o), 32'(1));
    @(posedge clk); #1;
    push_frame(1, 4, 16'h7000, 1'b1);
    wait_m(2, 20);
    rst_n = 1'b0;
    l_force = 1'b1; drive();
    @(negedge clk);
    chk("midframe_reset_outs",
        32'({s_rtr_o, m_rts_o, m_sow_o, m_eow_o, r_rts_o, err_o}), 32'(0));
    @(posedge clk); #1;
    do_reset();

    // Single frames: full, short, one-word; each result frame tagged with its owner.
    for (int i = 0; i < 5; i++) begin
      l_en = 1'b0;
      push_frame(vecs[i].k, vecs[i].n, vecs[i].base, vecs[i].exp_id);
      wait_m(0, 40);
      step(); step();
      chk("row_head_id", 32'(r_id_o), 32'(vecs[i].exp_id));
      chk("row_l_rtr_inflight", 32'(l_rtr_o), 32'(1));
      l_en = 1'b1; drive();
      drain(40);
      step();
      chk("row_l_rtr_empty", 32'(l_rtr_o), 32'(0));
    end
    chk("rows_err", 32'(err_o), 32'(0));

    // Both requesters busy: alternating grants, short s1 frame hands over to s0, bubble spacing.
    do_reset();
    push_frame(0, 4, 16'h2000, 1'b0);
    push_frame(1, 2, 16'h3000, 1'b1);
    push_frame(0, 4, 16'h2100, 1'b0);
    push_frame(1, 4, 16'h3100, 1'b1);
    drain(120);
    chk("t2_sow_count", 32'(sow_cyc.size()), 32'(4));
    if (sow_cyc.size() == 4) begin
      for (int i = 0; i < 3; i++) chk("t2_sow_gap", 32'(sow_cyc[i+1] - sow_cyc[i]), 32'(gaps[i]));
    end
    chk("t2_err", 32'(err_o), 32'(0));

    // FIFO full holds the third grant until the first result frame pops.
    do_reset();
    l_en = 1'b0;
    push_frame(0, 4, 16'h4000, 1'b0);
    push_frame(1, 4, 16'h5000, 1'b1);
    push_frame(0, 4, 16'h4100, 1'b0);
    wait_m(4, 40);
    repeat (5) step();
    chk("t4_hold_s_rtr", 32'(s_rtr_o), 32'(0));
    chk("t4_hold_m_rts", 32'(m_rts_o), 32'(0));
    l_en = 1'b1; drive();
    drain(80);
    if (sow_cyc.size() == 3 && pop_cyc.size() > 0)
      chk("t4_regrant_delay", 32'(sow_cyc[2] - pop_cyc[0]), 32'(2));
    else
      chk("t4_event_count", 32'({sow_cyc.size() == 3, pop_cyc.size() > 0}), 32'(3));
    chk("t4_err", 32'(err_o), 32'(0));

    // Stalling layer input and blocked downstream result path.
    do_reset();
    m_rtr_tog = 1'b1; r_en = 1'b0; drive();
    push_frame(0, 4, 16'h6000, 1'b0);
    wait_m(0, 40);
    repeat (3) step();
    chk("t5_l_rtr_held", 32'(l_rtr_o), 32'(0));
    chk("t5_r_rts_held", 32'(r_rts_o), 32'(1));
    if (rexp_q.size() > 0) chk("t5_r_posit_held", 32'(r_posit_o), 32'(rexp_q[0].d));
    r_en = 1'b1; m_rtr_tog = 1'b0; drive();
    drain(40);
    chk("t5_err", 32'(err_o), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
